iic_slave_regs: RTL and testbench

IIC_SLAVE_REGS -- requirements
Module: iic_slave_regs

---
 rtl/iic_slave_regs.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_iic_slave_regs.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_slave_regs.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// iic_slave_regs
//
// I2C slave that exposes a 16 x 8 register file to a bus master. It decodes
// one 7-bit device address and one word (register pointer) byte. After that
// it takes write data bytes, or returns read data bytes, with the pointer
// auto-incrementing and wrapping from 4'hF to 4'h0. SCL is only observed;
// the block never stretches the clock. SDA is driven open-drain. A registered
// local tap lets on-chip logic read any register at any time.
//
// Parameters
//   C_DEV_ADDR   7-bit I2C device address this slave answers to
//
// Ports
//   I_clk        system clock (50 MHz)
//   I_rst_n      asynchronous active-low reset
//   I_scl        I2C serial clock from the bus master
//   IO_sda       I2C data line; driven low or released, never driven high
//   I_user_addr  local tap address into the register file
//   O_user_data  registered register-file byte at I_user_addr
//   O_busy       high while an address-matched transaction is in progress
//   O_done_flag  one-cycle pulse on the STOP that ends a matched transaction
// ---------------------------------------------------------------------------
module iic_slave_regs #(
  parameter logic [6:0] C_DEV_ADDR = 7'h50
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_scl,
  inout  wire        IO_sda,
  input  logic [3:0] I_user_addr,
  output logic [7:0] O_user_data,
  output logic       O_busy,
  output logic       O_done_flag
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WORD,
    S_WORD_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_WAIT_STOP
  } state_e;

  // Each synchronizer chain: [0] first flop, [1] synchronized value,
  // [2] delayed copy of [1] used for edge detection.
  logic [2:0] sclSync_q;
  logic [2:0] sdaSync_q;

  logic       sclNow;
  logic       sclPrev;
  logic       sdaNow;
  logic       sdaPrev;
  logic       sclRise;
  logic       sclFall;
  logic       startDet;
  logic       stopDet;

  state_e     state_q,   state_d;
  logic [2:0] bitCnt_q,  bitCnt_d;
  logic [7:0] shift_q,   shift_d;
  logic [3:0] ptr_q,     ptr_d;
  logic       oe_q,      oe_d;
  logic       rw_q,      rw_d;
  logic       matched_q, matched_d;
  logic       done_q,    done_d;

  logic [7:0] regs_q [0:15];
  logic [7:0] userData_q;

  logic       wrEn;
  logic [7:0] rxByte;
  logic [7:0] rdByte;

  // Synchronizers. They reset to 1 so that an idle (pulled-up) bus does not
  // produce a false edge or condition when reset is released.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sclSync_q <= 3'b111;
      sdaSync_q <= 3'b111;
    end else begin
      sclSync_q <= {sclSync_q[1:0], I_scl};
      sdaSync_q <= {sdaSync_q[1:0], IO_sda};
    end
  end

  assign sclNow  = sclSync_q[1];
  assign sclPrev = sclSync_q[2];
  assign sdaNow  = sdaSync_q[1];
  assign sdaPrev = sdaSync_q[2];

  assign sclRise  =  sclNow & ~sclPrev;
  assign sclFall  = ~sclNow &  sclPrev;
  assign startDet =  sclNow &  sdaPrev & ~sdaNow;
  assign stopDet  =  sclNow & ~sdaPrev &  sdaNow;

  // Open-drain: only ever pull low.
  assign IO_sda = oe_q ? 1'b0 : 1'bz;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= S_IDLE;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      oe_q      <= 1'b0;
      rw_q      <= 1'b0;
      matched_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      rw_q      <= rw_d;
      matched_q <= matched_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic. STOP and START take priority over whatever the current
  // state is doing. In the three ACK states the output enable doubles as the
  // phase marker: the first SCL fall pulls SDA low, the second one releases
  // it and leaves the state.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    rw_d      = rw_q;
    matched_d = matched_q;
    done_d    = 1'b0;
    wrEn      = 1'b0;
    rxByte    = {shift_q[6:0], sdaNow};
    rdByte    = regs_q[ptr_q];

    if (stopDet) begin
      state_d   = S_IDLE;
      oe_d      = 1'b0;
      bitCnt_d  = '0;
      done_d    = matched_q;
      matched_d = 1'b0;
    end else if (startDet) begin
      state_d  = S_ADDR;
      oe_d     = 1'b0;
      bitCnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
        end

        S_ADDR: begin
          if (sclRise) begin
            shift_d  = rxByte;
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              if (rxByte[7:1] == C_DEV_ADDR) begin
                state_d   = S_ADDR_ACK;
                rw_d      = rxByte[0];
                matched_d = 1'b1;
              end else begin
                state_d = S_WAIT_STOP;
              end
            end
          end
        end

        S_ADDR_ACK: begin
          if (sclFall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d     = 1'b0;
              bitCnt_d = '0;
              if (rw_q) begin
                // The fall that ends the ACK also presents read bit 7.
                shift_d = rdByte;
                oe_d    = ~rdByte[7];
                state_d = S_RDATA;
              end else begin
                state_d = S_WORD;
              end
            end
          end
        end

        S_WORD: begin
          if (sclRise) begin
            shift_d  = rxByte;
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              ptr_d   = rxByte[3:0];
              state_d = S_WORD_ACK;
            end
          end
        end

        S_WORD_ACK: begin
          if (sclFall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d     = 1'b0;
              bitCnt_d = '0;
              state_d  = S_WDATA;
            end
          end
        end

        S_WDATA: begin
          if (sclRise) begin
            shift_d  = rxByte;
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              wrEn    = 1'b1;
              ptr_d   = ptr_q + 4'd1;
              state_d = S_WDATA_ACK;
            end
          end
        end

        S_WDATA_ACK: begin
          if (sclFall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d     = 1'b0;
              bitCnt_d = '0;
              state_d  = S_WDATA;
            end
          end
        end

        // The current bit always sits in shift_q[7]; bitCnt counts the
        // bits already presented after bit 7.
        S_RDATA: begin
          if (sclFall) begin
            if (bitCnt_q == 3'd7) begin
              oe_d     = 1'b0;
              bitCnt_d = '0;
              ptr_d    = ptr_q + 4'd1;
              state_d  = S_RDATA_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              oe_d     = ~shift_q[6];
              bitCnt_d = bitCnt_q + 3'd1;
            end
          end
        end

        // A NACK leaves on the rising edge, so the only fall seen here is
        // the one ending a master ACK, which starts the next read byte.
        S_RDATA_ACK: begin
          if (sclRise) begin
            if (sdaNow) begin
              state_d = S_WAIT_STOP;
            end
          end else if (sclFall) begin
            shift_d  = rdByte;
            oe_d     = ~rdByte[7];
            bitCnt_d = '0;
            state_d  = S_RDATA;
          end
        end

        S_WAIT_STOP: begin
          oe_d = 1'b0;
        end

        default: begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // Register file. Writes land on the 8th SCL rising edge of a data byte.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (wrEn) begin
      regs_q[ptr_q] <= rxByte;
    end
  end

  // Local tap: one cycle of latency; reads the stored array, so a bus write
  // shows up one cycle after it is stored.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      userData_q <= 8'h00;
    end else begin
      userData_q <= regs_q[I_user_addr];
    end
  end

  assign O_user_data = userData_q;
  assign O_busy      = matched_q;
  assign O_done_flag = done_q;

endmodule

// File: tb/tb_iic_slave_regs.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// tb_iic_slave_regs
//
// Bench for iic_slave_regs. A behavioural bus master drives SCL and pulls
// SDA low through an open-drain net with a pull-up. A register-file model is
// updated from the transactions the master issues. Expected read data and
// expected tap values are queued when the request is issued and popped when
// the DUT delivers the byte.
// ---------------------------------------------------------------------------
module tb_iic_slave_regs;

  localparam int Q = 100;

  logic       I_clk       = 1'b0;
  logic       I_rst_n     = 1'b0;
  logic       I_scl       = 1'b1;
  logic [3:0] I_user_addr = 4'h0;
  logic [7:0] O_user_data;
  logic       O_busy;
  logic       O_done_flag;
  logic       mSdaLow     = 1'b0;
  wire        sdaBus;

  assign sdaBus = mSdaLow ? 1'b0 : 1'bz;
  pullup (sdaBus);

  iic_slave_regs #(.C_DEV_ADDR(7'h50)) dut (
    .I_clk       (I_clk),
    .I_rst_n     (I_rst_n),
    .I_scl       (I_scl),
    .IO_sda      (sdaBus),
    .I_user_addr (I_user_addr),
    .O_user_data (O_user_data),
    .O_busy      (O_busy),
    .O_done_flag (O_done_flag)
  );

  always #10 I_clk = ~I_clk;

  int         errors     = 0;
  int         checks     = 0;
  int         doneCount  = 0;
  bit         busySeen   = 1'b0;
  bit         dutLowSeen = 1'b0;
  logic [7:0] model [16];
  logic [3:0] mPtr       = 4'h0;
  logic [7:0] expQ [$];

  // Passive monitors sampled away from the active edge.
  always @(negedge I_clk) begin
    if (O_done_flag === 1'b1) doneCount++;
    if (O_busy === 1'b1) busySeen = 1'b1;
    if (sdaBus === 1'b0 && !mSdaLow) dutLowSeen = 1'b1;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- bus master primitives ----------------
  task automatic i2cStart();
    @(posedge I_clk);
    #5;
    mSdaLow = 1'b0;
    #(Q);
    I_scl = 1'b1;
    #(Q);
    mSdaLow = 1'b1;
    #(Q);
    I_scl = 1'b0;
    #(Q);
  endtask

  task automatic i2cStop();
    mSdaLow = 1'b1;
    #(Q);
    I_scl = 1'b1;
    #(Q);
    mSdaLow = 1'b0;
    #(2*Q);
  endtask

  task automatic sendBit(input logic b);
    mSdaLow = ~b;
    #(Q);
    I_scl = 1'b1;
    #(2*Q);
    I_scl = 1'b0;
    #(Q);
  endtask

  task automatic recvBit(output logic b);
    mSdaLow = 1'b0;
    #(Q);
    I_scl = 1'b1;
    #(Q);
    b = sdaBus;
    #(Q);
    I_scl = 1'b0;
    #(Q);
  endtask

  // ackBit is the raw SDA level in the ACK slot: 0 means acknowledged.
  task automatic sendByte(input logic [7:0] d, output logic ackBit);
    for (int i = 7; i >= 0; i--) sendBit(d[i]);
    recvBit(ackBit);
  endtask

  task automatic recvByte(input logic masterAck, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recvBit(b);
      d[i] = b;
    end
    sendBit(~masterAck);
  endtask

  task automatic readTap(input logic [3:0] a, output logic [7:0] obs);
    @(negedge I_clk);
    I_user_addr = a;
    @(negedge I_clk);
    obs = O_user_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] obs, exp;
    #35;
    checks++;
    if (O_user_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_user_data: got %02h expected 00", O_user_data); end
    checks++;
    if (O_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", O_busy); end
    checks++;
    if (O_done_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", O_done_flag); end
    checks++;
    if (sdaBus !== 1'b1) begin errors++; $display("[TB] FAIL reset_sda: got %b expected 1", sdaBus); end
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    mPtr = 4'h0;
    @(negedge I_clk);
    I_rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      expQ.push_back(model[i]);
      readTap(4'(i), obs);
      exp = expQ.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL reset_reg[%0d]: got %02h expected %02h", i, obs, exp); end
    end
  endtask

  task automatic test_write();
    logic [7:0] seq [4];
    logic [7:0] obs, exp;
    logic       ack;
    int         d0;
    seq = '{8'hA0, 8'h03, 8'h5A, 8'hC3};
    d0 = doneCount;
    i2cStart();
    for (int i = 0; i < 4; i++) begin
      sendByte(seq[i], ack);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("[TB] FAIL write_ack[%0d]: got %b expected 0", i, ack); end
      if (i == 0) begin
        checks++;
        if (O_busy !== 1'b1) begin errors++; $display("[TB] FAIL write_busy: got %b expected 1", O_busy); end
      end
    end
    model[3] = 8'h5A;
    model[4] = 8'hC3;
    mPtr = 4'h5;
    i2cStop();
    checks++;
    if (doneCount - d0 != 1) begin errors++; $display("[TB] FAIL write_done_pulses: got %0d expected 1", doneCount - d0); end
    checks++;
    if (O_busy !== 1'b0) begin errors++; $display("[TB] FAIL write_busy_after_stop: got %b expected 0", O_busy); end
    for (int a = 3; a <= 4; a++) begin
      expQ.push_back(model[a]);
      readTap(4'(a), obs);
      exp = expQ.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL write_reg[%0d]: got %02h expected %02h", a, obs, exp); end
    end
  endtask

  task automatic test_random_read();
    logic [7:0] obs, exp;
    logic       ack;
    int         d0;
    d0 = doneCount;
    i2cStart();
    sendByte(8'hA0, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("[TB] FAIL rd_addr_w_ack: got %b expected 0", ack); end
    sendByte(8'h03, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("[TB] FAIL rd_word_ack: got %b expected 0", ack); end
    mPtr = 4'h3;
    i2cStart();
    sendByte(8'hA1, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("[TB] FAIL rd_addr_r_ack: got %b expected 0", ack); end
    for (int n = 0; n < 2; n++) begin
      expQ.push_back(model[mPtr]);
      recvByte(n == 0, obs);
      mPtr = mPtr + 4'd1;
      exp = expQ.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL rd_byte[%0d]: got %02h expected %02h", n, obs, exp); end
    end
    checks++;
    if (sdaBus !== 1'b1) begin errors++; $display("[TB] FAIL rd_sda_after_nack: got %b expected 1", sdaBus); end
    i2cStop();
    checks++;
    if (doneCount - d0 != 1) begin errors++; $display("[TB] FAIL rd_done_pulses: got %0d expected 1", doneCount - d0); end
  endtask

  task automatic test_wrong_addr();
    logic ack;
    int   d0;
    d0 = doneCount;
    dutLowSeen = 1'b0;
    busySeen   = 1'b0;
    i2cStart();
    sendByte(8'hA2, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("[TB] FAIL wrong_addr_ack: got %b expected 1", ack); end
    i2cStop();
    checks++;
    if (dutLowSeen !== 1'b0) begin errors++; $display("[TB] FAIL wrong_addr_sda_driven: got %b expected 0", dutLowSeen); end
    checks++;
    if (busySeen !== 1'b0) begin errors++; $display("[TB] FAIL wrong_addr_busy: got %b expected 0", busySeen); end
    checks++;
    if (doneCount - d0 != 0) begin errors++; $display("[TB] FAIL wrong_addr_done: got %0d expected 0", doneCount - d0); end
  endtask

  task automatic test_pointer_wrap();
    logic [7:0] seq [4];
    logic [7:0] obs, exp;
    logic [3:0] taps [2];
    logic       ack;
    seq  = '{8'hA0, 8'h0F, 8'h11, 8'h22};
    taps = '{4'hF, 4'h0};
    i2cStart();
    for (int i = 0; i < 4; i++) begin
      sendByte(seq[i], ack);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("[TB] FAIL wrap_ack[%0d]: got %b expected 0", i, ack); end
    end
    i2cStop();
    model[15] = 8'h11;
    model[0]  = 8'h22;
    mPtr = 4'h1;
    for (int i = 0; i < 2; i++) begin
      expQ.push_back(model[taps[i]]);
      readTap(taps[i], obs);
      exp = expQ.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL wrap_reg[%0d]: got %02h expected %02h", taps[i], obs, exp); end
    end
  endtask

  // Write two bytes, then re-address and read them back, chaining repeated
  // STARTs with no STOP in between.
  task automatic test_back_to_back();
    logic [7:0] seq [4];
    logic [7:0] obs, exp;
    logic       ack;
    int         d0;
    seq = '{8'hA0, 8'h08, 8'hAA, 8'hBB};
    d0 = doneCount;
    i2cStart();
    for (int i = 0; i < 4; i++) begin
      sendByte(seq[i], ack);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("[TB] FAIL b2b_wr_ack[%0d]: got %b expected 0", i, ack); end
    end
    model[8] = 8'hAA;
    model[9] = 8'hBB;
    i2cStart();
    sendByte(8'hA0, ack);
    sendByte(8'h08, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("[TB] FAIL b2b_word_ack: got %b expected 0", ack); end
    mPtr = 4'h8;
    i2cStart();
    sendByte(8'hA1, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rd_ack: got %b expected 0", ack); end
    for (int n = 0; n < 2; n++) begin
      expQ.push_back(model[mPtr]);
      recvByte(n == 0, obs);
      mPtr = mPtr + 4'd1;
      exp = expQ.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL b2b_rd_byte[%0d]: got %02h expected %02h", n, obs, exp); end
    end
    i2cStop();
    checks++;
    if (doneCount - d0 != 1) begin errors++; $display("[TB] FAIL b2b_done_pulses: got %0d expected 1", doneCount - d0); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] seq [3];
    logic [7:0] obs, exp;
    logic [7:0] addrW;
    logic       ack;
    seq   = '{8'hA0, 8'h07, 8'h99};
    addrW = 8'hA0;
    i2cStart();
    sendByte(8'hA0, ack);
    sendByte(8'h05, ack);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    mSdaLow = 1'b0;
    #(Q);
    I_scl = 1'b1;
    #(Q);
    I_rst_n = 1'b0;
    #1;
    checks++;
    if (sdaBus !== 1'b1) begin errors++; $display("[TB] FAIL midrst_sda: got %b expected 1", sdaBus); end
    checks++;
    if (O_busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", O_busy); end
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    mPtr = 4'h0;
    #(2*Q);
    I_rst_n = 1'b1;
    #(Q);
    for (int i = 0; i < 16; i++) begin
      expQ.push_back(model[i]);
      readTap(4'(i), obs);
      exp = expQ.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL midrst_reg[%0d]: got %02h expected %02h", i, obs, exp); end
    end
    // A full write after the reset behaves normally.
    i2cStart();
    for (int i = 0; i < 3; i++) begin
      sendByte(seq[i], ack);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("[TB] FAIL midrst_wr_ack[%0d]: got %b expected 0", i, ack); end
    end
    i2cStop();
    model[7] = 8'h99;
    mPtr = 4'h8;
    expQ.push_back(model[7]);
    readTap(4'h7, obs);
    exp = expQ.pop_front();
    checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL midrst_wr_reg7: got %02h expected %02h", obs, exp); end
    // Reset while the slave is pulling SDA low for an address ACK.
    i2cStart();
    for (int i = 7; i >= 0; i--) sendBit(addrW[i]);
    mSdaLow = 1'b0;
    #20;
    checks++;
    if (sdaBus !== 1'b0) begin errors++; $display("[TB] FAIL ackrst_sda_before: got %b expected 0", sdaBus); end
    I_rst_n = 1'b0;
    #1;
    checks++;
    if (sdaBus !== 1'b1) begin errors++; $display("[TB] FAIL ackrst_sda_after: got %b expected 1", sdaBus); end
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    mPtr = 4'h0;
    #(Q);
    I_rst_n = 1'b1;
    #(Q);
    // Without a fresh START the slave must not respond.
    sendByte(8'hA0, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("[TB] FAIL ackrst_no_start_ack: got %b expected 1", ack); end
    I_scl = 1'b1;
    #(Q);
  endtask

  task automatic test_stop_mid_byte();
    logic [7:0] obs, exp;
    logic       ack;
    int         d0;
    d0 = doneCount;
    i2cStart();
    sendByte(8'hA0, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("[TB] FAIL smb_addr_ack: got %b expected 0", ack); end
    sendByte(8'h02, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("[TB] FAIL smb_word_ack: got %b expected 0", ack); end
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    i2cStop();
    checks++;
    if (doneCount - d0 != 1) begin errors++; $display("[TB] FAIL smb_done_pulses: got %0d expected 1", doneCount - d0); end
    checks++;
    if (O_busy !== 1'b0) begin errors++; $display("[TB] FAIL smb_busy: got %b expected 0", O_busy); end
    expQ.push_back(model[2]);
    readTap(4'h2, obs);
    exp = expQ.pop_front();
    checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL smb_reg2: got %02h expected %02h", obs, exp); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_write();
    test_random_read();
    test_wrong_addr();
    test_pointer_wrap();
    test_back_to_back();
    test_mid_reset();
    test_stop_mid_byte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
